// File: rtl/nsc8_pkg.sv
// Shared definitions for the NSC8 program loader: state encoding,
// default data/address widths and the checksum width.
package nsc8_pkg;

    localparam int NSC8_N       = 8;
    localparam int NSC8_ADDR_W  = 4;
    localparam int NSC8_CKSUM_W = NSC8_N;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_ERROR   = 3'd4
    } loader_state_t;

endpackage

// File: rtl/nsc8_strobe_gen.sv
// Stretches a one-cycle start pulse into a strobe exactly CYCLES cycles
// wide. 'last' marks the final strobe cycle so the caller can move on.
module nsc8_strobe_gen #(
    parameter int CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic strobe,
    output logic last
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES - 1);

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;

    // Count strobe cycles from the start pulse until the last one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
        end else if (r_active) begin
            if (r_cnt == LAST_CNT) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign strobe = r_active;
    assign last   = r_active && (r_cnt == LAST_CNT);

endmodule

// File: rtl/nsc8_prog_loader.sv
// NSC8 program loader: streams program bytes into RAM while holding the
// CPU, then pulses the CPU restart strobes and releases it.
// Optional feature macro: NSC8_LOADER_CHECKSUM_EN (trailing checksum byte,
// ERROR state on mismatch). Default build has no checksum and err=0.
module nsc8_prog_loader
    import nsc8_pkg::*;
#(
    parameter int N              = NSC8_N,
    parameter int ADDR_W         = NSC8_ADDR_W,
    parameter int RELEASE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [N-1:0]      in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [N-1:0]      ram_wdata,
    output logic              cpu_hold,
    output logic              reset_counter,
    output logic              reset_ring,
    output logic              clear_ir,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    loader_state_t     r_state;
    loader_state_t     w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [N-1:0]      r_wdata;

    logic w_accept;
    logic w_term;
    logic w_cks_phase;
    logic w_data_accept;
    logic w_load_entry;
    logic w_start_release;
    logic w_strobe;
    logic w_strobe_last;

`ifdef NSC8_LOADER_CHECKSUM_EN
    logic [N-1:0] r_sum;
    logic         r_cks_phase;
    logic         w_cks_match;

    assign w_cks_phase = r_cks_phase;
    assign w_cks_match = (in_data == r_sum);
`else
    assign w_cks_phase = 1'b0;
`endif

    // A byte is taken whenever LOAD is active and the source offers one
    assign w_accept      = (r_state == ST_LOAD) && in_valid;
    assign w_term        = in_last || (r_addr == LAST_ADDR);
    assign w_data_accept = w_accept && !w_cks_phase;
    assign w_load_entry  = (r_state != ST_LOAD) && (w_state_next == ST_LOAD);
    assign w_start_release = (r_state == ST_LOAD) && (w_state_next == ST_RELEASE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        cpu_hold     = 1'b1;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_start) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (w_accept) begin
`ifdef NSC8_LOADER_CHECKSUM_EN
                    if (w_cks_phase) w_state_next = w_cks_match ? ST_RELEASE : ST_ERROR;
`else
                    if (w_term) w_state_next = ST_RELEASE;
`endif
                end
            end
            ST_RELEASE: begin
                if (w_strobe_last) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (load_start) w_state_next = ST_LOAD;
            end
            ST_ERROR: begin
`ifdef NSC8_LOADER_CHECKSUM_EN
                err = 1'b1;
`endif
                if (load_start) w_state_next = ST_LOAD;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Address counter, running checksum and the one-cycle RAM write stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
`ifdef NSC8_LOADER_CHECKSUM_EN
            r_sum       <= '0;
            r_cks_phase <= 1'b0;
`endif
        end else begin
            r_we <= w_data_accept;
            if (w_load_entry) begin
                r_addr <= '0;
`ifdef NSC8_LOADER_CHECKSUM_EN
                r_sum       <= '0;
                r_cks_phase <= 1'b0;
`endif
            end else if (w_data_accept) begin
                r_waddr <= r_addr;
                r_wdata <= in_data;
                r_addr  <= r_addr + ADDR_W'(1);
`ifdef NSC8_LOADER_CHECKSUM_EN
                r_sum <= r_sum + in_data;
                if (w_term) r_cks_phase <= 1'b1;
`endif
            end
        end
    end

    assign ram_we    = r_we;
    assign ram_addr  = r_waddr;
    assign ram_wdata = r_wdata;

    nsc8_strobe_gen #(
        .CYCLES (RELEASE_CYCLES)
    ) u_strobe_gen (
        .clk    (clk),
        .reset  (reset),
        .start  (w_start_release),
        .strobe (w_strobe),
        .last   (w_strobe_last)
    );

    assign reset_counter = w_strobe;
    assign reset_ring    = w_strobe;
    assign clear_ir      = w_strobe;

endmodule

// File: tb/tb_nsc8_prog_loader.sv
// Randomized self-checking bench for nsc8_prog_loader.
module tb_nsc8_prog_loader;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready, ram_we, cpu_hold, reset_counter, reset_ring, clear_ir, done, err;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct { int addr; int data; int c; } wr_t;
    wr_t wq[$];
    logic [7:0] prog [0:31];
    int acc_cyc [0:31];

    nsc8_prog_loader dut (
        .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .cpu_hold(cpu_hold),
        .reset_counter(reset_counter), .reset_ring(reset_ring), .clear_ir(clear_ir),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk) if (ram_we === 1'b1) wq.push_back('{int'(ram_addr), int'(ram_wdata), cyc});

    // Reference: number of bytes written for a given stream and terminator
    function automatic int exp_count(input int nbytes, input int last_idx);
        int k;
        k = (last_idx < 0) ? nbytes : last_idx + 1;
        return (k > DEPTH) ? DEPTH : k;
    endfunction

    task automatic pulse_start();
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
    endtask

    // Drive a byte stream while LOAD is active; mode 0 = steady valid,
    // 1 = valid every other cycle, 2 = random valid plus stray load_start
    task automatic do_load(input int nbytes, input int last_idx, input int mode,
                           output int n_acc, output int last_c, output bit tmo);
        int idx; bit v;
        idx = 0; last_c = 0; tmo = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (in_ready !== 1'b1) begin tmo = 1'b0; break; end
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            if (idx >= nbytes) v = 1'b0;
            in_valid = v;
            in_data  = prog[idx];
            in_last  = v ? (idx == last_idx) : 1'($urandom_range(0, 1));
            if (mode == 2) load_start = ($urandom_range(0, 3) == 0);
            if (v) begin acc_cyc[idx] = cyc; last_c = cyc; idx++; end
        end
        in_valid = 1'b0; in_last = 1'b0; load_start = 1'b0;
        n_acc = idx;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, reset_counter, reset_ring, clear_ir, done, err} !== {2'b00, 4'h0, 8'h00, 1'b1, 5'b00000}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b we=%b addr=%0d wd=%0h hold=%b str=%b%b%b done=%b err=%b, want 0 0 0 0 1 000 0 0",
                     in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, reset_counter, reset_ring, clear_ir, done, err);
        end
        reset = 1'b0;
        $display("reset: released");
    endtask

    // Load, then check release strobe, RUN entry and every RAM write
    task automatic load_and_check(input string tag, input int nbytes, input int last_idx, input int mode);
        int n, lc, k; bit tmo;
        k = exp_count(nbytes, last_idx);
        wq.delete();
        do_load(nbytes, last_idx, mode, n, lc, tmo);
        checks++;
        if (tmo) begin
            errors++;
            $display("FAIL %s_timeout: LOAD never ended, want end after %0d bytes", tag, k);
        end
        checks++;
        if (n != k) begin
            errors++;
            $display("FAIL %s_accepted: got %0d bytes, want %0d", tag, n, k);
        end
        checks++;
        if ({reset_counter, reset_ring, clear_ir, cpu_hold, done, in_ready} !== 6'b111100 || cyc != lc + 1) begin
            errors++;
            $display("FAIL %s_release: got str=%b%b%b hold=%b done=%b rdy=%b cyc=%0d, want 111 1 0 0 cyc=%0d",
                     tag, reset_counter, reset_ring, clear_ir, cpu_hold, done, in_ready, cyc, lc + 1);
        end
        @(negedge clk); #1;
        checks++;
        if ({reset_counter, reset_ring, clear_ir, cpu_hold, done} !== 5'b00001) begin
            errors++;
            $display("FAIL %s_run: got str=%b%b%b hold=%b done=%b, want 000 0 1",
                     tag, reset_counter, reset_ring, clear_ir, cpu_hold, done);
        end
        checks++;
        if (wq.size() != k) begin
            errors++;
            $display("FAIL %s_nwrites: got %0d, want %0d", tag, wq.size(), k);
        end
        for (int i = 0; i < wq.size() && i < k; i++) begin
            checks++;
            if (wq[i].addr != i || wq[i].data != int'(prog[i]) || wq[i].c != acc_cyc[i] + 1) begin
                errors++;
                $display("FAIL %s_write%0d: got addr=%0d data=%0h cyc=%0d, want addr=%0d data=%0h cyc=%0d",
                         tag, i, wq[i].addr, wq[i].data, wq[i].c, i, prog[i], acc_cyc[i] + 1);
            end
        end
        $display("%s: %0d bytes, last_idx=%0d, mode=%0d, %0d writes", tag, nbytes, last_idx, mode, wq.size());
    endtask

    task automatic test_full_load();
        for (int i = 0; i < 32; i++) prog[i] = 8'(i);
        pulse_start();
        load_and_check("full_load", 16, -1, 0);
    endtask

    task automatic test_early_last();
        prog[0] = 8'hE0; prog[1] = 8'hF0; prog[2] = 8'h00; prog[3] = 8'h55;
        pulse_start();
        #1;
        checks++;
        if ({cpu_hold, done, in_ready} !== 3'b101) begin
            errors++;
            $display("FAIL reload_entry: got hold=%b done=%b rdy=%b, want 1 0 1", cpu_hold, done, in_ready);
        end
        load_and_check("early_last", 4, 2, 0);
    endtask

    task automatic test_toggle_valid();
        for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
        pulse_start();
        load_and_check("toggle_valid", 16, -1, 1);
    endtask

    task automatic test_random_loads();
        int nb, li, md;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                nb = $urandom_range(16, 24); li = -1;
            end else begin
                nb = $urandom_range(1, 24); li = $urandom_range(0, nb - 1);
            end
            md = $urandom_range(1, 2);
            pulse_start();
            #1;
            checks++;
            if ({cpu_hold, done} !== 2'b10) begin
                errors++;
                $display("FAIL random_reload_entry: got hold=%b done=%b, want 1 0", cpu_hold, done);
            end
            load_and_check("random_load", nb, li, md);
        end
    endtask

    task automatic test_valid_in_run();
        wq.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'($urandom_range(0, 1));
        end
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (wq.size() != 0 || done !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL valid_in_run: got writes=%0d done=%b rdy=%b, want 0 1 0", wq.size(), done, in_ready);
        end
        $display("valid_in_run: %0d writes", wq.size());
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        wq.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            prog[i] = 8'($urandom);
            in_valid = 1'b1; in_data = prog[i]; in_last = 1'b0;
        end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, reset_counter, reset_ring, clear_ir, done, err} !== {2'b00, 4'h0, 8'h00, 1'b1, 5'b00000}) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b we=%b addr=%0d wd=%0h hold=%b str=%b%b%b done=%b err=%b, want 0 0 0 0 1 000 0 0",
                     in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, reset_counter, reset_ring, clear_ir, done, err);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (wq.size() != 5) begin
            errors++;
            $display("FAIL reset_writes: got %0d writes, want 5", wq.size());
        end
        for (int i = 0; i < wq.size() && i < 5; i++) begin
            checks++;
            if (wq[i].addr != i || wq[i].data != int'(prog[i])) begin
                errors++;
                $display("FAIL reset_write%0d: got addr=%0d data=%0h, want addr=%0d data=%0h",
                         i, wq[i].addr, wq[i].data, i, prog[i]);
            end
        end
        $display("reset_mid_load: %0d writes before reset", wq.size());
        reset = 1'b0;
        for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
        pulse_start();
        load_and_check("after_reset", 4, 3, 0);
    endtask

`ifdef NSC8_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int n, lc; bit tmo;
        prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h03;
        pulse_start();
        wq.delete();
        do_load(3, 1, 0, n, lc, tmo);
        checks++;
        if (tmo || n != 3 || {reset_counter, cpu_hold} !== 2'b11) begin
            errors++;
            $display("FAIL cks_good_release: got tmo=%b n=%0d str=%b hold=%b, want 0 3 1 1", tmo, n, reset_counter, cpu_hold);
        end
        @(negedge clk); #1;
        checks++;
        if ({done, err, cpu_hold} !== 3'b100 || wq.size() != 2) begin
            errors++;
            $display("FAIL cks_good_run: got done=%b err=%b hold=%b writes=%0d, want 1 0 0 2", done, err, cpu_hold, wq.size());
        end
        $display("checksum_good: %0d writes", wq.size());
        prog[2] = 8'h04;
        pulse_start();
        do_load(3, 1, 0, n, lc, tmo);
        checks++;
        if (tmo || n != 3 || {err, cpu_hold, reset_counter, reset_ring, clear_ir, done} !== 6'b110000) begin
            errors++;
            $display("FAIL cks_bad_error: got tmo=%b n=%0d err=%b hold=%b str=%b%b%b done=%b, want 0 3 1 1 000 0",
                     tmo, n, err, cpu_hold, reset_counter, reset_ring, clear_ir, done);
        end
        @(negedge clk); #1;
        checks++;
        if ({err, cpu_hold, reset_counter, done} !== 4'b1100) begin
            errors++;
            $display("FAIL cks_bad_hold: got err=%b hold=%b str=%b done=%b, want 1 1 0 0", err, cpu_hold, reset_counter, done);
        end
        pulse_start();
        #1;
        checks++;
        if ({err, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL cks_error_exit: got err=%b rdy=%b, want 0 1", err, in_ready);
        end
        $display("checksum_bad: err=%b after reload", err);
    endtask
`endif

    initial begin
        test_reset();
`ifdef NSC8_LOADER_CHECKSUM_EN
        test_checksum();
`else
        test_full_load();
        test_early_last();
        test_toggle_valid();
        test_valid_in_run();
        test_random_loads();
        test_reset_mid_load();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
